// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states, iteration count
// and two's-complement helpers.
package mdu_pkg;

    localparam int unsigned IterCount = 32;

    typedef enum logic [2:0] {
        MduNop   = 3'd0,
        MduMult  = 3'd1,
        MduMultu = 3'd2,
        MduDiv   = 3'd3,
        MduDivu  = 3'd4,
        MduMthi  = 3'd5,
        MduMtlo  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Operand/control/result bundle between the datapath controller and the MDU.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output A, B, MDUOp, Start,
        input  Busy, HI, LO
    );

    modport slave (
        input  A, B, MDUOp, Start,
        output Busy, HI, LO
    );
endinterface

// File: rtl/mdu_iter.sv
// One iteration of the unsigned multiply/divide datapath on a 65-bit accumulator.
// Multiply: acc = {partial product, multiplier}, shift-add right.
// Divide:   acc = {partial remainder, dividend/quotient}, restoring shift-subtract left.
module mdu_iter (
    input  logic [64:0] acc_i,
    input  logic [31:0] opnd_i,
    input  logic        is_div_i,
    output logic [64:0] acc_o
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic        no_borrow;

    // Select shift-add or shift-subtract result for this cycle
    always_comb begin
        sum       = acc_i[64:32] + {1'b0, (acc_i[0] ? opnd_i : 32'd0)};
        // Shifted remainder window is acc_i[64:31]; bit 64 set means it already exceeds opnd
        diff      = acc_i[63:31] - {1'b0, opnd_i};
        no_borrow = acc_i[64] | (acc_i[63:31] >= {1'b0, opnd_i});
        if (is_div_i) begin
            acc_o = no_borrow ? {diff, acc_i[30:0], 1'b1} : {acc_i[63:0], 1'b0};
        end else begin
            acc_o = {1'b0, sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO.
// Operands are reduced to magnitudes on accept, iterated 32 times, then sign-fixed on write.
module mdu
    import mdu_pkg::*;
(
    input logic  clk,
    input logic  rstn,
    mdu_if.slave bus
);

    localparam logic [5:0] CntLast = 6'(IterCount - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] acc_q, acc_d, acc_step;
    logic [31:0] opnd_q, opnd_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        op_signed, op_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    mdu_iter u_iter (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_step)
    );

    // Operand magnitudes on accept and sign-corrected results for the FIX write
    always_comb begin
        op_signed = (bus.MDUOp == MduMult) || (bus.MDUOp == MduDiv);
        op_div    = (bus.MDUOp == MduDiv) || (bus.MDUOp == MduDivu);
        a_neg     = op_signed & bus.A[31];
        b_neg     = op_signed & bus.B[31];
        a_mag     = a_neg ? neg32(bus.A) : bus.A;
        b_mag     = b_neg ? neg32(bus.B) : bus.B;

        prod_fix  = neg_res_q ? neg64(acc_q[63:0]) : acc_q[63:0];
        quo_fix   = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? neg32(acc_q[31:0]) : acc_q[31:0]);
        // On divide-by-zero the remainder is the dividend magnitude, so this restores A
        rem_fix   = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
    end

    // FSM next state, iteration control and HI/LO updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    case (bus.MDUOp)
                        MduMult, MduMultu, MduDiv, MduDivu: begin
                            state_d   = StRun;
                            cnt_d     = 6'd0;
                            is_div_d  = op_div;
                            acc_d     = {33'd0, (op_div ? a_mag : b_mag)};
                            opnd_d    = op_div ? b_mag : a_mag;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = op_div & a_neg;
                            div0_d    = op_div & (bus.B == 32'd0);
                        end
                        MduMthi: hi_d = bus.A;
                        MduMtlo: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            acc_q     <= 65'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.Busy = (state_q != StIdle);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: expected HI/LO from a behavioural model are queued when an
// operation is issued and compared when the unit drops Busy.
module tb_mdu;
    import mdu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t scb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_if bus ();

    mdu u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        hi = 32'd0;
        lo = 32'd0;
        if (op == MduMult) begin
            p  = 64'(longint'($signed(a)) * longint'($signed(b)));
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == MduMultu) begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else begin
            sa = (op == MduDiv) ? longint'($signed(a)) : longint'({32'd0, a});
            sb = (op == MduDiv) ? longint'($signed(b)) : longint'({32'd0, b});
            q  = sa / sb;
            r  = sa % sb;
            hi = 32'(r);
            lo = 32'(q);
        end
    endfunction

    // Issue a multi-cycle op; optionally inject another request while Busy
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj_at, input logic [2:0] inj_op,
                          input logic [31:0] inj_a);
        exp_t e;
        int   n;
        e.tag = tag;
        model(op, a, b, e.hi, e.lo);
        scb.push_back(e);
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        n = 0;
        while (bus.Busy && n < 100) begin
            n++;
            if (n == inj_at) begin
                bus.Start = 1'b1;
                bus.MDUOp = inj_op;
                bus.A     = inj_a;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'd33);
        e = scb.pop_front();
        check({e.tag, "_hi"}, bus.HI, e.hi);
        check({e.tag, "_lo"}, bus.LO, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    // Single-cycle request issued from idle; Busy must stay low
    task automatic idle_op(input string tag, input logic [2:0] op, input logic [31:0] a);
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = $urandom;
        bus.Start = 1'b1;
        if (op == MduMthi) m_hi = a;
        if (op == MduMtlo) m_lo = a;
        @(negedge clk);
        bus.Start = 1'b0;
        check({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
        check({tag, "_hi"}, bus.HI, m_hi);
        check({tag, "_lo"}, bus.LO, m_lo);
    endtask

    initial begin
        logic [2:0] rop;
        logic [31:0] ra, rb;

        bus.Start = 1'b0;
        bus.MDUOp = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            bus.A     = $urandom;
            bus.B     = $urandom;
            bus.MDUOp = 3'($urandom_range(0, 7));
            bus.Start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        bus.Start = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("post_rst_hi", bus.HI, 32'd0);
        check("post_rst_lo", bus.LO, 32'd0);

        // Directed arithmetic, issued back to back (next start lands on E34)
        run_op("multu_max", MduMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, MduNop, 32'd0);
        run_op("mult_neg", MduMult, 32'hFFFF_FFFD, 32'd7, 0, MduNop, 32'd0);
        run_op("div_neg", MduDiv, 32'hFFFF_FFF9, 32'd2, 0, MduNop, 32'd0);
        run_op("divu_small", MduDivu, 32'd7, 32'd2, 0, MduNop, 32'd0);
        run_op("divu_by0", MduDivu, 32'h0000_1234, 32'd0, 0, MduNop, 32'd0);
        run_op("div_ovf", MduDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0, MduNop, 32'd0);
        run_op("div_neg_by0", MduDiv, 32'hFFFF_FFFB, 32'd0, 0, MduNop, 32'd0);
        run_op("div_rem_neg", MduDiv, 32'hFFFF_FF9C, 32'd7, 0, MduNop, 32'd0);
        run_op("mult_both_neg", MduMult, 32'h8000_0000, 32'h8000_0000, 0, MduNop, 32'd0);

        // Random operands, divisors of varied magnitude
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            run_op("rand", rop, ra, rb, 0, MduNop, 32'd0);
        end

        // Requests while Busy are ignored, MTHI included
        run_op("div_mthi_ignored", MduDiv, 32'd100, 32'd7, 5, MduMthi, 32'h0000_BEEF);
        run_op("mul_mtlo_ignored", MduMultu, 32'd3, 32'd5, 20, MduMtlo, 32'h0000_1111);

        // Single-cycle moves and no-op codes from idle
        idle_op("mthi", MduMthi, 32'h1111_2222);
        idle_op("mtlo", MduMtlo, 32'h3333_4444);
        idle_op("nop", MduNop, 32'h5555_6666);
        idle_op("reserved", 3'd7, 32'h7777_8888);

        // Asynchronous reset in the middle of a divide
        bus.MDUOp = MduDiv;
        bus.A     = 32'd1000;
        bus.B     = 32'd3;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_div_busy", {31'd0, bus.Busy}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("async_rst_hi", bus.HI, 32'd0);
        check("async_rst_lo", bus.LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        idle_op("mtlo_after_rst", MduMtlo, 32'h0000_CAFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
